// File: rtl/manhattan_sequence_detector.sv
// Moore FSM that pulses detector_out for one cycle after each serial 1-1-0-1-0-1.
// Define MANHATTAN_SEQDET_OVERLAP_EN to let a match's final 1 start the next pattern.
module manhattan_sequence_detector (
  input  logic sequence_in,
  input  logic clock,
  input  logic reset,
  output logic detector_out
);

  // Each state names the longest pattern prefix seen so far.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle / no prefix
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4,  // "1101"
    S5 = 3'd5,  // "11010"
    S6 = 3'd6   // match
  } state_e;

  state_e state_q;
  state_e state_d;

  // NOTE: the state register uses non-blocking assignment so every flop samples the pre-edge value.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    state_d = S0;
    case (state_q)
      S0: state_d = sequence_in ? S1 : S0;
      S1: state_d = sequence_in ? S2 : S0;
      S2: state_d = sequence_in ? S2 : S3;
      S3: state_d = sequence_in ? S4 : S0;
      S4: state_d = sequence_in ? S2 : S5;
      S5: state_d = sequence_in ? S6 : S0;
`ifdef MANHATTAN_SEQDET_OVERLAP_EN
      S6: state_d = sequence_in ? S2 : S0;
`else
      S6: state_d = sequence_in ? S1 : S0;
`endif
      default: state_d = S0;  // unused 3'b111 recovers to idle
    endcase
  end

  // Decoded from the register alone, so the output carries no path from sequence_in.
  assign detector_out = (state_q == S6);

endmodule

// File: tb/tb_manhattan_sequence_detector.sv
// Bench for manhattan_sequence_detector: sliding-window reference model checked every
// cycle, plus directed streams with hand-computed pulse positions.
module tb_manhattan_sequence_detector;

`ifdef MANHATTAN_SEQDET_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif
  localparam logic [5:0] PATTERN = 6'b110101;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sequence_in = 1'b0;
  logic detector_out;

  int passed = 0;
  int total = 0;

  manhattan_sequence_detector dut (
    .sequence_in (sequence_in),
    .clock       (clock),
    .reset       (reset),
    .detector_out(detector_out)
  );

  always #5 clock = ~clock;

  task automatic check(input logic actual, input logic expected, input string name);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %b, required %b at %0t", name, actual, expected, $time);
  endtask

  // Reference: the last six bits counted since reset (or since the previous match
  // when matches may not share bits) must equal the pattern.
  logic [5:0] hist_q = '0;
  int         len_q = 0;
  logic       exp_out = 1'b0;
  logic       model_ready = 1'b0;

  always @(posedge clock) begin
    logic [5:0] nh;
    int         nl;
    logic       hit;
    if (reset) begin
      hist_q      <= '0;
      len_q       <= 0;
      exp_out     <= 1'b0;
      model_ready <= 1'b1;
    end else begin
      nh  = {hist_q[4:0], sequence_in};
      nl  = (len_q < 6) ? len_q + 1 : 6;
      hit = (nl == 6) && (nh == PATTERN);
      exp_out <= hit;
      if (hit && !OVERLAP) begin
        hist_q <= '0;
        len_q  <= 0;
      end else begin
        hist_q <= nh;
        len_q  <= nl;
      end
    end
  end

  always @(negedge clock) begin
    if (model_ready) check(detector_out, exp_out, "model");
  end

  // Inputs change on the falling edge; the output is checked at the next falling edge.
  task automatic do_reset(input logic bit_during_reset);
    @(negedge clock);
    reset       = 1'b1;
    sequence_in = bit_during_reset;
    @(posedge clock);
    @(negedge clock);
    check(detector_out, 1'b0, "reset_out");
    reset = 1'b0;
  endtask

  // bits/pulses hold the stream first-bit-first in their low n bits, MSB side first.
  task automatic run_stream(input logic [15:0] bits, input logic [15:0] pulses,
                            input int n, input string name);
    for (int i = 0; i < n; i++) begin
      sequence_in = bits[n-1-i];
      @(posedge clock);
      @(negedge clock);
      check(detector_out, pulses[n-1-i], name);
    end
    sequence_in = 1'b0;
  endtask

  initial begin
    do_reset(1'b0);
    run_stream(16'b110101, 16'b000001, 6, "basic");

    do_reset(1'b0);
    run_stream(16'b101010, 16'b000000, 6, "alternating");

    do_reset(1'b0);
    run_stream(16'b1101011, 16'b0000010, 7, "trailing_one");

    // Runs of ones must hold the "11" prefix, so a later 0101 completes a match.
    do_reset(1'b0);
    run_stream(16'b1111110101, 16'b0000000001, 10, "ones_then_tail");

    do_reset(1'b0);
    if (OVERLAP) run_stream(16'b11010110101, 16'b00000100001, 11, "shared_one");
    else         run_stream(16'b11010110101, 16'b00000100000, 11, "shared_one");

    do_reset(1'b0);
    run_stream(16'b110101110101, 16'b000001000001, 12, "back_to_back");

    // Partial progress is discarded by reset, and the bit on the reset edge is ignored.
    do_reset(1'b0);
    run_stream(16'b1101, 16'b0000, 4, "pre_reset");
    do_reset(1'b1);
    run_stream(16'b01, 16'b00, 2, "post_reset");

    @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
